// File: rtl/cvm300_pkg.sv
// Shared definitions for the CVM300 capture sequencer: state encoding,
// default parameter values and a small constant helper.
package cvm300_pkg;

   // Sequencer states; the encoding is exported on state_dbg.
   typedef enum logic [3:0] {
      ST_SENSOR_RST = 4'd0,
      ST_IDLE       = 4'd1,
      ST_FIFO_RST   = 4'd2,
      ST_DELAY      = 4'd3,
      ST_FREQ       = 4'd4,
      ST_WAIT_FRAME = 4'd5,
      ST_DONE       = 4'd6
   } state_t;

   localparam int DEF_FRAME_CNT_W     = 8;
   localparam int DEF_DELAY_W         = 16;
   localparam int DEF_TIMEOUT_W       = 24;
   localparam int DEF_REQ_PULSE       = 1;
   localparam int DEF_FIFO_RST_CYCLES = 4;

   // Larger of two widths, used to size the shared phase timer.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter with a terminal flag. load has priority over counting;
// the counter parks at zero and done stays high until the next load.
module pulse_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] cnt_r;

   // Load a new interval or count down towards zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= {W{1'b0}};
      end else if (load) begin
         cnt_r <= load_val;
      end else if (cnt_r != {W{1'b0}}) begin
         cnt_r <= cnt_r - ONE;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign done = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/cvm300_capture_sequencer.sv
// CVM300 frame-capture sequencer: sensor reset release, FIFO reset pulse,
// settle delay, FRAME_REQ pulses for single/burst/continuous capture, with a
// per-frame timeout and status counters. One shared pulse_timer times every
// phase because only one phase is ever active.
module cvm300_capture_sequencer
   import cvm300_pkg::*;
#(
   parameter int FRAME_CNT_W     = DEF_FRAME_CNT_W,
   parameter int DELAY_W         = DEF_DELAY_W,
   parameter int TIMEOUT_W       = DEF_TIMEOUT_W,
   parameter int REQ_PULSE       = DEF_REQ_PULSE,
   parameter int FIFO_RST_CYCLES = DEF_FIFO_RST_CYCLES
) (
   input  logic                   FSM_Clk,
   input  logic                   reset,
   input  logic                   sys_rst_cmd,
   input  logic                   grab_cmd,
   input  logic                   abort,
   input  logic                   continuous,
   input  logic [FRAME_CNT_W-1:0] num_frames,
   input  logic [DELAY_W-1:0]     delay_cycles,
   input  logic [TIMEOUT_W-1:0]   timeout_cycles,
   input  logic                   frame_done,
   output logic                   sensor_res_n,
   output logic                   fifo_reset,
   output logic                   frame_req,
   output logic                   busy,
   output logic [FRAME_CNT_W-1:0] frames_captured,
   output logic                   timeout_err,
   output logic [3:0]             state_dbg
);

   localparam int TMR_W = max_int(DELAY_W, TIMEOUT_W);

   // Timer reload values: a load of N-1 keeps the phase for N cycles.
   localparam logic [TMR_W-1:0]       FIFO_LOAD   = TMR_W'(FIFO_RST_CYCLES - 1);
   localparam logic [TMR_W-1:0]       REQ_LOAD    = TMR_W'(REQ_PULSE - 1);
   localparam logic [TIMEOUT_W-1:0]   TIMEOUT_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
   localparam logic [FRAME_CNT_W-1:0] FRAMES_ONE  = {{(FRAME_CNT_W-1){1'b0}}, 1'b1};
   localparam logic [FRAME_CNT_W-1:0] FRAMES_MAX  = {FRAME_CNT_W{1'b1}};

   state_t                 state_r;
   state_t                 next_state_s;

   logic                   grab_q_r;
   logic                   start_s;

   // Configuration captured at start
   logic                   continuous_r;
   logic [FRAME_CNT_W-1:0] eff_frames_r;
   logic [DELAY_W-1:0]     delay_r;
   logic [TIMEOUT_W-1:0]   timeout_r;

   // Registered outputs
   logic                   sensor_res_n_r;
   logic                   fifo_reset_r;
   logic                   frame_req_r;
   logic                   busy_r;
   logic [FRAME_CNT_W-1:0] frames_r;
   logic                   timeout_err_r;

   // Decode results for this cycle
   logic [FRAME_CNT_W:0]   frames_inc_s;
   logic                   last_frame_s;
   logic                   timeout_en_s;
   logic                   start_hit_s;
   logic                   frame_hit_s;
   logic                   timeout_hit_s;

   logic                   tmr_load_s;
   logic [TMR_W-1:0]       tmr_val_s;
   logic                   tmr_done_s;

   assign start_s      = grab_cmd & ~grab_q_r;
   assign frames_inc_s = {1'b0, frames_r} + {{FRAME_CNT_W{1'b0}}, 1'b1};
   assign timeout_en_s = (timeout_r != {TIMEOUT_W{1'b0}});
   // Continuous runs end on the frame that arrives after grab_cmd was dropped.
   assign last_frame_s = continuous_r ? ~grab_cmd
                                      : (frames_inc_s >= {1'b0, eff_frames_r});

   pulse_timer #(
      .W (TMR_W)
   ) u_timer (
      .clk      (FSM_Clk),
      .rst      (reset),
      .load     (tmr_load_s),
      .load_val (tmr_val_s),
      .done     (tmr_done_s)
   );

   // Next-state selection with sensor reset over abort over normal flow, plus
   // the timer reload for whichever timed phase is being entered.
   always_comb begin
      next_state_s  = state_r;
      start_hit_s   = 1'b0;
      frame_hit_s   = 1'b0;
      timeout_hit_s = 1'b0;
      tmr_load_s    = 1'b0;
      tmr_val_s     = {TMR_W{1'b0}};

      if (!sys_rst_cmd) begin
         next_state_s = ST_SENSOR_RST;
      end else if (abort && (state_r != ST_SENSOR_RST)) begin
         next_state_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_SENSOR_RST: begin
               next_state_s = ST_IDLE;
            end
            ST_IDLE: begin
               if (start_s) begin
                  next_state_s = ST_FIFO_RST;
                  start_hit_s  = 1'b1;
               end else begin
                  next_state_s = ST_IDLE;
               end
            end
            ST_FIFO_RST: begin
               if (tmr_done_s) begin
                  next_state_s = ST_DELAY;
               end else begin
                  next_state_s = ST_FIFO_RST;
               end
            end
            ST_DELAY: begin
               if (tmr_done_s) begin
                  next_state_s = ST_FREQ;
               end else begin
                  next_state_s = ST_DELAY;
               end
            end
            ST_FREQ: begin
               if (tmr_done_s) begin
                  next_state_s = ST_WAIT_FRAME;
               end else begin
                  next_state_s = ST_FREQ;
               end
            end
            ST_WAIT_FRAME: begin
               // A frame landing on the expiry cycle still counts.
               if (frame_done) begin
                  frame_hit_s = 1'b1;
                  if (last_frame_s) begin
                     next_state_s = ST_DONE;
                  end else begin
                     next_state_s = ST_FREQ;
                  end
               end else if (timeout_en_s && tmr_done_s) begin
                  timeout_hit_s = 1'b1;
                  next_state_s  = ST_DONE;
               end else begin
                  next_state_s = ST_WAIT_FRAME;
               end
            end
            ST_DONE: begin
               next_state_s = ST_IDLE;
            end
            default: begin
               next_state_s = ST_SENSOR_RST;
            end
         endcase
      end

      if (next_state_s != state_r) begin
         case (next_state_s)
            ST_FIFO_RST: begin
               tmr_load_s = 1'b1;
               tmr_val_s  = FIFO_LOAD;
            end
            ST_DELAY: begin
               tmr_load_s = 1'b1;
               tmr_val_s  = TMR_W'(delay_r);
            end
            ST_FREQ: begin
               tmr_load_s = 1'b1;
               tmr_val_s  = REQ_LOAD;
            end
            ST_WAIT_FRAME: begin
               tmr_load_s = 1'b1;
               tmr_val_s  = timeout_en_s ? TMR_W'(timeout_r - TIMEOUT_ONE)
                                         : {TMR_W{1'b0}};
            end
            default: begin
               tmr_load_s = 1'b0;
               tmr_val_s  = {TMR_W{1'b0}};
            end
         endcase
      end else begin
         tmr_load_s = 1'b0;
         tmr_val_s  = {TMR_W{1'b0}};
      end
   end

   // State register and pin outputs, registered from the next state so each
   // pin changes on the same edge as the state it belongs to.
   always_ff @(posedge FSM_Clk or posedge reset) begin
      if (reset) begin
         state_r        <= ST_SENSOR_RST;
         grab_q_r       <= 1'b0;
         sensor_res_n_r <= 1'b0;
         fifo_reset_r   <= 1'b0;
         frame_req_r    <= 1'b0;
         busy_r         <= 1'b0;
      end else begin
         state_r        <= next_state_s;
         grab_q_r       <= grab_cmd;
         sensor_res_n_r <= (next_state_s != ST_SENSOR_RST);
         fifo_reset_r   <= (next_state_s == ST_FIFO_RST);
         frame_req_r    <= (next_state_s == ST_FREQ);
         busy_r         <= (next_state_s != ST_IDLE) && (next_state_s != ST_SENSOR_RST);
      end
   end

   // Capture configuration and clear status at start; afterwards count frames
   // (saturating) and record a timeout. Status survives sensor reset and abort.
   always_ff @(posedge FSM_Clk or posedge reset) begin
      if (reset) begin
         continuous_r  <= 1'b0;
         eff_frames_r  <= FRAMES_ONE;
         delay_r       <= {DELAY_W{1'b0}};
         timeout_r     <= {TIMEOUT_W{1'b0}};
         frames_r      <= {FRAME_CNT_W{1'b0}};
         timeout_err_r <= 1'b0;
      end else if (start_hit_s) begin
         continuous_r  <= continuous;
         eff_frames_r  <= (num_frames == {FRAME_CNT_W{1'b0}}) ? FRAMES_ONE : num_frames;
         delay_r       <= delay_cycles;
         timeout_r     <= timeout_cycles;
         frames_r      <= {FRAME_CNT_W{1'b0}};
         timeout_err_r <= 1'b0;
      end else begin
         if (frame_hit_s && (frames_r != FRAMES_MAX)) begin
            frames_r <= frames_inc_s[FRAME_CNT_W-1:0];
         end
         if (timeout_hit_s) begin
            timeout_err_r <= 1'b1;
         end
      end
   end

   assign sensor_res_n    = sensor_res_n_r;
   assign fifo_reset      = fifo_reset_r;
   assign frame_req       = frame_req_r;
   assign busy            = busy_r;
   assign frames_captured = frames_r;
   assign timeout_err     = timeout_err_r;
   assign state_dbg       = state_r;

endmodule
